// File: rtl/neo_pkg.sv
`default_nettype none
// ============================================================================
// Package : neo_pkg
// Shared types, default timing and width helpers for the NeoPixel strand engine.
// Rev     : 1.0 - initial release
// ============================================================================
package neo_pkg;

  localparam int DEF_NUM_PIXELS   = 8;
  localparam int DEF_T0H          = 18;
  localparam int DEF_T0L          = 40;
  localparam int DEF_T1H          = 35;
  localparam int DEF_T1L          = 30;
  localparam int DEF_LATCH_CYCLES = 2500;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'b00,
    COLOR_BLUE  = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_WHITE = 2'b11
  } color_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2
  } phase_e;

  // Wire order on the strand is G, R, B, so G sits in the top byte.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  // Bits needed to hold the value n.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items.
  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neo_strand_engine_if.sv
`default_nettype none
// ============================================================================
// Interface : neo_strand_engine_if
// Front-end load/send bus and strand-side status; NEO_BRIGHTNESS_EN adds brightness.
// Rev       : 1.0 - initial release
// ============================================================================
interface neo_strand_engine_if #(
  parameter int NUM_PIXELS = 8
);
  import neo_pkg::*;

  localparam int PW = index_width(NUM_PIXELS);

  logic          load_color;
  logic [PW-1:0] pixel_index;
  logic [1:0]    color_index;
  logic [7:0]    color_level;
  logic          send_it;
`ifdef NEO_BRIGHTNESS_EN
  logic [7:0]    brightness;
`endif
  logic          neo_data;
  logic          ready_to_load;
  logic          ready_to_send;
  logic          busy;

`ifdef NEO_BRIGHTNESS_EN
  modport master (
    output load_color, pixel_index, color_index, color_level, send_it, brightness,
    input  neo_data, ready_to_load, ready_to_send, busy
  );
  modport slave (
    input  load_color, pixel_index, color_index, color_level, send_it, brightness,
    output neo_data, ready_to_load, ready_to_send, busy
  );
`else
  modport master (
    output load_color, pixel_index, color_index, color_level, send_it,
    input  neo_data, ready_to_load, ready_to_send, busy
  );
  modport slave (
    input  load_color, pixel_index, color_index, color_level, send_it,
    output neo_data, ready_to_load, ready_to_send, busy
  );
`endif

endinterface
`default_nettype wire

// File: rtl/neo_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module : neo_bit_encoder
// Produces one WS2812 bit waveform (high then low phase) per accepted start.
// Rev    : 1.0 - initial release
// ============================================================================
module neo_bit_encoder
  import neo_pkg::*;
#(
  parameter int T0H = DEF_T0H,
  parameter int T0L = DEF_T0L,
  parameter int T1H = DEF_T1H,
  parameter int T1L = DEF_T1L
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  input  logic bit_i,
  output logic data_o,
  output logic done_o
);

  localparam int CW = width_for(max2(max2(T0H, T0L), max2(T1H, T1L)));
  localparam logic [CW-1:0] T0H_LOAD = CW'(T0H - 1);
  localparam logic [CW-1:0] T0L_LOAD = CW'(T0L - 1);
  localparam logic [CW-1:0] T1H_LOAD = CW'(T1H - 1);
  localparam logic [CW-1:0] T1L_LOAD = CW'(T1L - 1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] cnt_q;
  logic          bit_q;
  logic          data_q;
  logic          cnt_zero;
  logic          take;

  assign cnt_zero = (cnt_q == '0);
  // A start in the last low cycle chains straight into the next bit.
  assign take = start_i && ((phase_q == PH_IDLE) || ((phase_q == PH_LOW) && cnt_zero));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) phase_q <= PH_IDLE;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE: if (start_i) phase_d = PH_HIGH;
      PH_HIGH: if (cnt_zero) phase_d = PH_LOW;
      PH_LOW:  if (cnt_zero) phase_d = start_i ? PH_HIGH : PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  always_comb begin
    done_o = (phase_q == PH_LOW) && cnt_zero;
    data_o = data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      bit_q  <= 1'b0;
      data_q <= 1'b0;
    end else begin
      data_q <= (phase_d == PH_HIGH);
      if (take) begin
        cnt_q <= bit_i ? T1H_LOAD : T0H_LOAD;
        bit_q <= bit_i;
      end else if ((phase_q == PH_HIGH) && cnt_zero) begin
        cnt_q <= bit_q ? T1L_LOAD : T0L_LOAD;
      end else if (!cnt_zero) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/neo_strand_engine.sv
`default_nettype none
// ============================================================================
// Module : neo_strand_engine
// Double-buffered NeoPixel strand driver; NEO_BRIGHTNESS_EN enables per-frame brightness.
// Rev    : 1.0 - initial release
// ============================================================================
module neo_strand_engine
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int T0H          = DEF_T0H,
  parameter int T0L          = DEF_T0L,
  parameter int T1H          = DEF_T1H,
  parameter int T1L          = DEF_T1L,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  neo_strand_engine_if.slave bus
);

  localparam int PW         = index_width(NUM_PIXELS);
  localparam int TOTAL_BITS = NUM_PIXELS * 24;
  localparam int BW         = width_for(TOTAL_BITS);
  localparam int LW         = width_for(LATCH_CYCLES);
  localparam logic [BW-1:0] TOTAL_BITS_C = BW'(TOTAL_BITS);
  localparam logic [LW-1:0] LATCH_LOAD   = LW'(LATCH_CYCLES - 1);
  localparam logic [PW:0]   NUM_PIX_C    = (PW + 1)'(NUM_PIXELS);

  pixel_t [NUM_PIXELS-1:0] shadow_q, shadow_d;
  pixel_t [NUM_PIXELS-1:0] active_q;
  state_e        state_q, state_d;
  logic          first_q;
  logic [BW-1:0] bit_cnt_q;
  logic [PW-1:0] pix_q;
  logic [4:0]    bitpos_q;
  logic [LW-1:0] latch_cnt_q;
`ifdef NEO_BRIGHTNESS_EN
  logic [7:0]    bright_q;
`endif

  logic   accept;
  logic   enc_start;
  logic   enc_bit;
  logic   enc_data;
  logic   enc_done;
  logic   more_bits;
  pixel_t cur_pixel;
  logic [7:0] raw_byte;
  logic [7:0] tx_byte;

  // shadow_d is the post-write image, so a send in the same cycle captures the write.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.load_color && ({1'b0, bus.pixel_index} < NUM_PIX_C)) begin
      case (color_sel_e'(bus.color_index))
        COLOR_RED:   shadow_d[bus.pixel_index].r = bus.color_level;
        COLOR_BLUE:  shadow_d[bus.pixel_index].b = bus.color_level;
        COLOR_GREEN: shadow_d[bus.pixel_index].g = bus.color_level;
        default: begin
          shadow_d[bus.pixel_index].g = bus.color_level;
          shadow_d[bus.pixel_index].r = bus.color_level;
          shadow_d[bus.pixel_index].b = bus.color_level;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.send_it) state_d = ST_HIGH;
      ST_HIGH, ST_LOW: begin
        if (enc_done)                                         state_d = more_bits ? ST_HIGH : ST_LATCH;
        else if ((state_q == ST_HIGH) && !first_q && !enc_data) state_d = ST_LOW;
      end
      ST_LATCH: if (latch_cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept            = (state_q == ST_IDLE) && bus.send_it;
    bus.ready_to_send = (state_q == ST_IDLE);
    bus.busy          = (state_q != ST_IDLE);
    bus.ready_to_load = 1'b1;
    bus.neo_data      = enc_data;
    enc_start         = 1'b0;
    if ((state_q == ST_HIGH) && first_q)
      enc_start = 1'b1;
    else if (((state_q == ST_HIGH) || (state_q == ST_LOW)) && enc_done && more_bits)
      enc_start = 1'b1;
  end

  assign more_bits = (bit_cnt_q != TOTAL_BITS_C);
  assign cur_pixel = active_q[pix_q];

  always_comb begin
    case (bitpos_q[4:3])
      2'd1:    raw_byte = cur_pixel.r;
      2'd2:    raw_byte = cur_pixel.b;
      default: raw_byte = cur_pixel.g;
    endcase
`ifdef NEO_BRIGHTNESS_EN
    tx_byte = 8'((16'(raw_byte) * (16'(bright_q) + 16'd1)) >> 8);
`else
    tx_byte = raw_byte;
`endif
    enc_bit = tx_byte[3'd7 - bitpos_q[2:0]];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q    <= '0;
      first_q     <= 1'b0;
      bit_cnt_q   <= '0;
      pix_q       <= '0;
      bitpos_q    <= '0;
      latch_cnt_q <= '0;
`ifdef NEO_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      if (accept) begin
        active_q  <= shadow_d;
        first_q   <= 1'b1;
        bit_cnt_q <= '0;
        pix_q     <= '0;
        bitpos_q  <= '0;
`ifdef NEO_BRIGHTNESS_EN
        bright_q  <= bus.brightness;
`endif
      end else if (enc_start) begin
        first_q   <= 1'b0;
        bit_cnt_q <= bit_cnt_q + BW'(1);
        if (bitpos_q == 5'd23) begin
          bitpos_q <= '0;
          pix_q    <= pix_q + PW'(1);
        end else begin
          bitpos_q <= bitpos_q + 5'd1;
        end
      end
      if (state_q == ST_LATCH) latch_cnt_q <= latch_cnt_q - LW'(1);
      else                     latch_cnt_q <= LATCH_LOAD;
    end
  end

  neo_bit_encoder #(
    .T0H (T0H),
    .T0L (T0L),
    .T1H (T1H),
    .T1L (T1L)
  ) u_encoder (
    .clock   (clock),
    .reset   (reset),
    .start_i (enc_start),
    .bit_i   (enc_bit),
    .data_o  (enc_data),
    .done_o  (enc_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_neo_strand_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_neo_strand_engine
// Directed bench for neo_strand_engine (3 pixels, default timing); NEO_BRIGHTNESS_EN aware.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_neo_strand_engine;

  localparam int NP     = 3;
  localparam int NBITS  = NP * 24;
  localparam int T0H    = 18;
  localparam int T0L    = 40;
  localparam int T1H    = 35;
  localparam int T1L    = 30;
  localparam int LATCH  = 2500;
  localparam int BOUND  = 5000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  neo_strand_engine_if #(.NUM_PIXELS(NP)) bus();

  neo_strand_engine #(.NUM_PIXELS(NP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int hi_len [NBITS];
  int lo_len [NBITS];
  logic [71:0] frame;
  int lat, bad, last_lo;
  int cnt_a, cnt_b, tcount;
  logic prev;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] px, input logic [1:0] ch, input logic [7:0] lv);
    bus.load_color  = 1'b1;
    bus.pixel_index = px;
    bus.color_index = ch;
    bus.color_level = lv;
    @(posedge clock);
    #1 bus.load_color = 1'b0;
  endtask

  task automatic send();
    bus.send_it = 1'b1;
    @(posedge clock);
    #1 bus.send_it = 1'b0;
  endtask

  // Decodes one frame from pulse widths; called #1 after the edge that took send_it.
  task automatic recv_frame(output logic [71:0] fr, output int lat_o, output int bad_o, output int last_o);
    int h, l;
    logic tmo;
    fr = '0; lat_o = 0; bad_o = 0; last_o = 0; tmo = 1'b0;
    @(negedge clock);
    while (bus.neo_data !== 1'b1 && lat_o < 100) begin
      lat_o++;
      @(negedge clock);
    end
    if (lat_o >= 100) tmo = 1'b1;
    for (int i = 0; i < NBITS && !tmo; i++) begin
      h = 0;
      while (bus.neo_data === 1'b1 && h < BOUND) begin h++; @(negedge clock); end
      l = 0;
      while (bus.neo_data === 1'b0 && bus.ready_to_send === 1'b0 && l < BOUND) begin l++; @(negedge clock); end
      if (h >= BOUND || l >= BOUND) tmo = 1'b1;
      hi_len[i] = h;
      lo_len[i] = l;
      fr = {fr[70:0], (h == T1H)};
      if (i == NBITS - 1) last_o = l;
      else if (!((h == T1H && l == T1L) || (h == T0H && l == T0L))) bad_o++;
    end
    check_eq("recv_bound", 72'(tmo), 72'd0);
  endtask

  initial begin
    bus.load_color  = 1'b0;
    bus.pixel_index = '0;
    bus.color_index = 2'b00;
    bus.color_level = 8'h00;
    bus.send_it     = 1'b0;
`ifdef NEO_BRIGHTNESS_EN
    bus.brightness  = 8'd255;
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Idle after reset
    check_eq("rst_neo_data", 72'(bus.neo_data), 72'd0);
    check_eq("rst_ready_to_load", 72'(bus.ready_to_load), 72'd1);
    check_eq("rst_ready_to_send", 72'(bus.ready_to_send), 72'd1);
    check_eq("rst_busy", 72'(bus.busy), 72'd0);

    // G=80 R=01 B=00 on pixel 0
    load(2'd0, 2'b10, 8'h80);
    load(2'd0, 2'b00, 8'h01);
    send();
    check_eq("send_busy", 72'(bus.busy), 72'd1);
    check_eq("send_rts", 72'(bus.ready_to_send), 72'd0);
    recv_frame(frame, lat, bad, last_lo);
    check_eq("t1_latency", 72'(lat), 72'd1);
    check_eq("t1_frame", frame, 72'h800100_000000_000000);
    check_eq("t1_b0_high", 72'(hi_len[0]), 72'd35);
    check_eq("t1_b0_low", 72'(lo_len[0]), 72'd30);
    check_eq("t1_b1_high", 72'(hi_len[1]), 72'd18);
    check_eq("t1_b1_low", 72'(lo_len[1]), 72'd40);
    check_eq("t1_b15_high", 72'(hi_len[15]), 72'd35);
    check_eq("t1_bad_bits", 72'(bad), 72'd0);
    check_eq("t1_last_low", 72'(last_lo), 72'(T0L + LATCH));
    check_eq("t1_rts_back", 72'(bus.ready_to_send), 72'd1);
    sync();

    // White A5 on pixel 2, out-of-range pixel 3 ignored
    load(2'd0, 2'b11, 8'h00);
    load(2'd2, 2'b11, 8'hA5);
    load(2'd3, 2'b11, 8'hFF);
    send();
    recv_frame(frame, lat, bad, last_lo);
    check_eq("t2_frame", frame, 72'h000000_000000_A5A5A5);
    check_eq("t2_bad_bits", 72'(bad), 72'd0);
    sync();

    // Double buffering: shadow write at bit ~10 must not reach this frame
    load(2'd0, 2'b11, 8'hFF);
    load(2'd1, 2'b11, 8'hFF);
    load(2'd2, 2'b11, 8'hFF);
    send();
    fork
      recv_frame(frame, lat, bad, last_lo);
      begin
        repeat (660) @(posedge clock);
        #1 load(2'd0, 2'b10, 8'h00);
      end
    join
    check_eq("t3_frame_ones", frame, {72{1'b1}});
    check_eq("t3_last_low", 72'(last_lo), 72'(T1L + LATCH));
    sync();
    send();
    recv_frame(frame, lat, bad, last_lo);
    check_eq("t3_next_frame", frame, 72'h00FFFF_FFFFFF_FFFFFF);
    sync();

    // Load and send in the same cycle; send_it during LATCH ignored
    bus.load_color  = 1'b1;
    bus.pixel_index = 2'd0;
    bus.color_index = 2'b00;
    bus.color_level = 8'h3C;
    bus.send_it     = 1'b1;
    @(posedge clock);
    #1 bus.load_color = 1'b0;
    bus.send_it = 1'b0;
    fork
      recv_frame(frame, lat, bad, last_lo);
      begin
        cnt_a = 0;
        tcount = 0;
        while (cnt_a < 200 && tcount < 20000) begin
          @(negedge clock);
          tcount++;
          if (bus.busy && !bus.neo_data) cnt_a++;
          else cnt_a = 0;
        end
        @(posedge clock);
        #1 send();
      end
    join
    check_eq("t4_frame", frame, 72'h003CFF_FFFFFF_FFFFFF);
    cnt_a = 0;
    cnt_b = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.neo_data) cnt_a++;
      if (bus.busy) cnt_b++;
    end
    check_eq("t4_no_requeue_data", 72'(cnt_a), 72'd0);
    check_eq("t4_no_requeue_busy", 72'(cnt_b), 72'd0);
    sync();

    // Asynchronous reset in the high phase of bit 5
    send();
    cnt_a = 0;
    tcount = 0;
    prev = 1'b0;
    while (cnt_a < 6 && tcount < 2000) begin
      @(negedge clock);
      tcount++;
      if (bus.neo_data && !prev) cnt_a++;
      prev = bus.neo_data;
    end
    check_eq("t5_mid_high", 72'(bus.neo_data), 72'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_data", 72'(bus.neo_data), 72'd0);
    check_eq("t5_async_busy", 72'(bus.busy), 72'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    check_eq("t5_rts_after", 72'(bus.ready_to_send), 72'd1);
    load(2'd0, 2'b10, 8'h81);
    send();
    recv_frame(frame, lat, bad, last_lo);
    check_eq("t5_resend", frame, 72'h810000_000000_000000);
    check_eq("t5_latency", 72'(lat), 72'd1);
    sync();

`ifdef NEO_BRIGHTNESS_EN
    load(2'd0, 2'b11, 8'hFF);
    bus.brightness = 8'd127;
    send();
    bus.brightness = 8'd255;
    recv_frame(frame, lat, bad, last_lo);
    check_eq("br127_frame", frame, 72'h7F7F7F_000000_000000);
    sync();
    bus.brightness = 8'd0;
    send();
    recv_frame(frame, lat, bad, last_lo);
    check_eq("br0_frame", frame, 72'h000000_000000_000000);
    sync();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
